gcm_seq_ctrl: RTL and testbench
===============================

// Module: gcm_seq_ctrl
// PURPOSE
// Command sequencer in front of the gcm core. Accepts one typed 128-bit command stream (KEY/IV/AAD/DATA)
// over valid/ready and drives the core's one-hot strobes in a legal order and spacing. Inserts the stalls
// needed for key expansion and H/J0 generation, issues gcm_end, then waits for the tag. Counts returned
// blocks and reports done/error to the host.
// PARAMETERS
// KEY_LAT   11  idle cycles after a KEY strobe before the next command may issue (key expansion)
// IV_GAP    2   idle cycles after an IV strobe before AAD/DATA/end may issue (J0 slot + H load)
// TAG_TMO   64  max cycles in TAG_WAIT before timeout error
// CNT_W     16  width of block counters
// PORTS
// clk             in   1    clock
// rst_n           in   1    synchronous active-low reset
// cmd_vld_i       in   1    command valid
// cmd_rdy_o       out  1    command ready; transfer when vld & rdy
// cmd_type_i      in   2    00 KEY, 01 IV, 10 AAD, 11 DATA
// cmd_last_i      in   1    final block of message (IV/AAD/DATA); ignored for KEY
// cmd_data_i      in   128  key / IV (bits 127:32 used) / AAD / plaintext block
// gcm_key_vld_o   out  1    key strobe to core
// gcm_key_o       out  128  key to core
// gcm_iv_vld_o    out  1    IV strobe to core
// gcm_aad_vld_o   out  1    AAD strobe to core
// gcm_data_vld_o  out  1    DATA strobe to core
// gcm_data_o      out  128  block to core (IV/AAD/DATA)
// gcm_end_o       out  1    end-of-message pulse to core
// core_vld_i      in   1    core output-block valid (gcm_data_vld_o of core)
// core_tag_vld_i  in   1    core tag valid
// busy_o          out  1    message in progress (IV accepted, tag not yet seen)
// done_o          out  1    1-cycle pulse: tag received, counts matched
// err_o           out  1    sticky error; cleared only by reset or an accepted KEY
// BEHAVIOUR
// - All outputs registered; reset (sync, rst_n=0 at posedge) -> state IDLE, all outputs 0, counters 0, err_o 0.
// - States: IDLE (no key) -> KEY_WAIT -> READY -> IV_WAIT -> AAD -> DATA -> TAG_WAIT -> READY; ERR absorbing until reset/KEY.
// - Strobes: at most one of key/iv/aad/data/end high per cycle; each strobe is a 1-cycle pulse, driven the cycle after the accepting handshake.
// - IDLE: cmd_rdy_o=1; KEY -> strobe, KEY_WAIT. Non-KEY command -> accept, drop, set err_o, stay IDLE.
// - KEY_WAIT: rdy=0 for KEY_LAT cycles (down-counter), then READY.
// - READY: rdy=1. KEY -> reload key, KEY_WAIT. IV -> strobe, clear counters, busy_o=1, IV_WAIT. AAD/DATA -> err, drop.
// - IV_WAIT: rdy=0 for IV_GAP cycles. Then: if IV had last=1 (empty message), pulse gcm_end_o and go TAG_WAIT; else AAD.
// - AAD: rdy=1. AAD -> strobe, in_cnt++. DATA -> strobe, in_cnt++, move to DATA. Back-to-back blocks allowed (1/cycle).
// - DATA: rdy=1. DATA -> strobe, in_cnt++. AAD after DATA, or IV/KEY mid-message -> ERR (drop, busy_o=0).
// - last=1 on AAD/DATA: block strobed at cycle t, gcm_end_o pulses at t+1, rdy=0 from accept, enter TAG_WAIT.
// - TAG_WAIT: rdy=0; out_cnt++ per core_vld_i (also counted in AAD/DATA states). On core_tag_vld_i:
//   out_cnt==in_cnt -> done_o pulse next cycle, busy_o=0, READY; mismatch -> ERR. TAG_TMO cycles without tag -> ERR.
// - core_vld_i or core_tag_vld_i while not busy -> err_o set (spurious output).
// - Counters saturate at 2^CNT_W-1; saturation of in_cnt -> ERR.
// - Reset mid-message: everything returns to IDLE, key must be reloaded; no strobes issued during reset cycle.
// - ERR: rdy=1 and drops everything except KEY, which clears err_o and goes KEY_WAIT.
// TESTING
// - Reset then KEY=0 (all zero) -> gcm_key_vld_o 1 cycle, rdy low 11 cycles; IV=0 last=1 -> gcm_end_o 3 cycles after IV strobe; tag=58E2FCCEFA7E3061367F1D57A4E7455A matched, done_o pulse.
// - 2 AAD + 3 DATA back-to-back, last on 3rd DATA -> strobes on 5 consecutive cycles, end next cycle, 5 core_vld_i + tag -> done_o.
// - AAD sent after DATA -> err_o=1, busy_o=0, no gcm_aad_vld_o; then KEY -> err_o cleared.
// - DATA directly after KEY (no IV) -> err_o=1, no gcm_data_vld_o issued.
// - Withhold core_tag_vld_i -> err_o asserted exactly 64 cycles after TAG_WAIT entry; 4 in / 3 out with tag -> err_o, no done_o.
// - Assert rst_n=0 in DATA state -> next cycle all outputs 0, state IDLE, IV rejected until KEY reloaded.

Source files
------------

// File: rtl/gcm_seq_ctrl_if.sv
// Host command stream into the gcm sequencer: typed 128-bit blocks over valid/ready.
// Signal names are given from the sequencer's point of view.
interface gcm_seq_ctrl_if;
  logic         cmd_vld_i;
  logic         cmd_rdy_o;
  logic [1:0]   cmd_type_i;
  logic         cmd_last_i;
  logic [127:0] cmd_data_i;

  modport master (
    output cmd_vld_i,
    output cmd_type_i,
    output cmd_last_i,
    output cmd_data_i,
    input  cmd_rdy_o
  );

  modport slave (
    input  cmd_vld_i,
    input  cmd_type_i,
    input  cmd_last_i,
    input  cmd_data_i,
    output cmd_rdy_o
  );
endinterface

// File: rtl/gcm_seq_ctrl.sv
// Command sequencer for the gcm core: orders KEY/IV/AAD/DATA strobes, inserts the key-expansion
// and J0 stalls, issues gcm_end and checks the returned block count against the blocks sent.
module gcm_seq_ctrl #(
  parameter int unsigned KEY_LAT = 11,
  parameter int unsigned IV_GAP  = 2,
  parameter int unsigned TAG_TMO = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gcm_seq_ctrl_if.slave        cmd,
  output logic                 gcm_key_vld_o,
  output logic [127:0]         gcm_key_o,
  output logic                 gcm_iv_vld_o,
  output logic                 gcm_aad_vld_o,
  output logic                 gcm_data_vld_o,
  output logic [127:0]         gcm_data_o,
  output logic                 gcm_end_o,
  input  logic                 core_vld_i,
  input  logic                 core_tag_vld_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [1:0] CmdKey  = 2'b00;
  localparam logic [1:0] CmdIv   = 2'b01;
  localparam logic [1:0] CmdAad  = 2'b10;
  localparam logic [1:0] CmdData = 2'b11;

  localparam int unsigned WaitMax = (KEY_LAT > IV_GAP) ? KEY_LAT : IV_GAP;
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);
  localparam int unsigned TmoW    = (TAG_TMO > 1) ? $clog2(TAG_TMO) : 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    StIdle, StKeyWait, StReady, StIvWait, StAad, StData, StTagWait, StErr
  } state_e;

  state_e             state_q;
  logic [WaitW-1:0]   wait_q;
  logic [TmoW-1:0]    tmo_q;
  logic [CNT_W-1:0]   in_cnt_q, out_cnt_q;
  logic               iv_last_q, end_pend_q, rdy_q;
  logic               key_vld_q, iv_vld_q, aad_vld_q, data_vld_q, end_q;
  logic [127:0]       key_q, blk_q;
  logic               busy_q, done_q, err_q;

  logic               acc;
  logic [CNT_W-1:0]   in_cnt_inc, out_cnt_nxt;

  always_comb begin
    acc         = cmd.cmd_vld_i & rdy_q;
    in_cnt_inc  = (in_cnt_q == CntMax) ? in_cnt_q : in_cnt_q + 1'b1;
    out_cnt_nxt = (core_vld_i && (out_cnt_q != CntMax)) ? out_cnt_q + 1'b1 : out_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      tmo_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      iv_last_q  <= 1'b0;
      end_pend_q <= 1'b0;
      rdy_q      <= 1'b0;
      key_vld_q  <= 1'b0;
      key_q      <= '0;
      iv_vld_q   <= 1'b0;
      aad_vld_q  <= 1'b0;
      data_vld_q <= 1'b0;
      blk_q      <= '0;
      end_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      key_vld_q  <= 1'b0;
      iv_vld_q   <= 1'b0;
      aad_vld_q  <= 1'b0;
      data_vld_q <= 1'b0;
      end_q      <= 1'b0;
      done_q     <= 1'b0;
      // Core output outside a message is spurious.
      if (busy_q) begin
        out_cnt_q <= out_cnt_nxt;
      end else if (core_vld_i || core_tag_vld_i) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle, StReady, StErr: begin
          rdy_q <= 1'b1;
          if (acc) begin
            if (cmd.cmd_type_i == CmdKey) begin
              key_vld_q <= 1'b1;
              key_q     <= cmd.cmd_data_i;
              err_q     <= 1'b0;
              rdy_q     <= 1'b0;
              wait_q    <= WaitW'(KEY_LAT - 1);
              state_q   <= StKeyWait;
            end else if (state_q == StReady && cmd.cmd_type_i == CmdIv) begin
              iv_vld_q  <= 1'b1;
              blk_q     <= {cmd.cmd_data_i[127:32], 32'h0};
              iv_last_q <= cmd.cmd_last_i;
              in_cnt_q  <= '0;
              out_cnt_q <= '0;
              busy_q    <= 1'b1;
              rdy_q     <= 1'b0;
              wait_q    <= WaitW'(IV_GAP - 1);
              state_q   <= StIvWait;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        StKeyWait: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - 1'b1;
          end else begin
            rdy_q   <= 1'b1;
            state_q <= StReady;
          end
        end

        StIvWait: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - 1'b1;
          end else if (iv_last_q) begin
            end_pend_q <= 1'b1;
            tmo_q      <= '0;
            state_q    <= StTagWait;
          end else begin
            rdy_q   <= 1'b1;
            state_q <= StAad;
          end
        end

        StAad, StData: begin
          if (acc) begin
            if ((cmd.cmd_type_i == CmdAad && state_q == StAad) || cmd.cmd_type_i == CmdData) begin
              if (in_cnt_inc == CntMax) begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                rdy_q   <= 1'b1;
                state_q <= StErr;
              end else begin
                in_cnt_q   <= in_cnt_inc;
                blk_q      <= cmd.cmd_data_i;
                aad_vld_q  <= (cmd.cmd_type_i == CmdAad);
                data_vld_q <= (cmd.cmd_type_i == CmdData);
                if (cmd.cmd_type_i == CmdData) state_q <= StData;
                if (cmd.cmd_last_i) begin
                  rdy_q      <= 1'b0;
                  end_pend_q <= 1'b1;
                  tmo_q      <= '0;
                  state_q    <= StTagWait;
                end
              end
            end else begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
              state_q <= StErr;
            end
          end
        end

        StTagWait: begin
          // gcm_end trails the final strobe by one cycle.
          if (end_pend_q) begin
            end_q      <= 1'b1;
            end_pend_q <= 1'b0;
          end
          if (core_tag_vld_i) begin
            if (out_cnt_nxt == in_cnt_q) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
              state_q <= StReady;
            end else begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
              state_q <= StErr;
            end
          end else if (tmo_q == TmoW'(TAG_TMO - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= StErr;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign cmd.cmd_rdy_o    = rdy_q;
  assign gcm_key_vld_o    = key_vld_q;
  assign gcm_key_o        = key_q;
  assign gcm_iv_vld_o     = iv_vld_q;
  assign gcm_aad_vld_o    = aad_vld_q;
  assign gcm_data_vld_o   = data_vld_q;
  assign gcm_data_o       = blk_q;
  assign gcm_end_o        = end_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_gcm_seq_ctrl.sv
// Bench for gcm_seq_ctrl: directed scenarios plus random messages checked against a
// transaction-level expectation (strobe order/data, stall lengths, done iff counts match).
module tb_gcm_seq_ctrl;

  localparam logic [1:0] CmdKey  = 2'b00;
  localparam logic [1:0] CmdIv   = 2'b01;
  localparam logic [1:0] CmdAad  = 2'b10;
  localparam logic [1:0] CmdData = 2'b11;
  localparam int KeyLat = 11;
  localparam int IvGap  = 2;
  localparam int TagTmo = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gcm_seq_ctrl_if cmd_if ();

  logic         gcm_key_vld_o, gcm_iv_vld_o, gcm_aad_vld_o, gcm_data_vld_o, gcm_end_o;
  logic [127:0] gcm_key_o, gcm_data_o;
  logic         core_vld_i, core_tag_vld_i;
  logic         busy_o, done_o, err_o;

  gcm_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd            (cmd_if),
    .gcm_key_vld_o  (gcm_key_vld_o),
    .gcm_key_o      (gcm_key_o),
    .gcm_iv_vld_o   (gcm_iv_vld_o),
    .gcm_aad_vld_o  (gcm_aad_vld_o),
    .gcm_data_vld_o (gcm_data_vld_o),
    .gcm_data_o     (gcm_data_o),
    .gcm_end_o      (gcm_end_o),
    .core_vld_i     (core_vld_i),
    .core_tag_vld_i (core_tag_vld_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int n_aad = 0, n_data = 0, n_multi = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (gcm_aad_vld_o)  n_aad  <= n_aad + 1;
    if (gcm_data_vld_o) n_data <= n_data + 1;
    if ($countones({gcm_key_vld_o, gcm_iv_vld_o, gcm_aad_vld_o, gcm_data_vld_o, gcm_end_o}) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic probe(input int sel);
    case (sel)
      0:       return cmd_if.cmd_rdy_o;
      1:       return gcm_end_o;
      default: return err_o;
    endcase
  endfunction

  // Cycles (sampled after each edge) until the probed signal goes high; bounded.
  task automatic wait_hi(input int sel, output int n);
    n = 0;
    while (probe(sel) !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
  endtask

  // Present one command and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [1:0] t, input logic l, input logic [127:0] d);
    int k;
    cmd_if.cmd_vld_i  = 1'b1;
    cmd_if.cmd_type_i = t;
    cmd_if.cmd_last_i = l;
    cmd_if.cmd_data_i = d;
    k = 0;
    while (cmd_if.cmd_rdy_o !== 1'b1 && k < 200) begin
      cyc(1);
      k++;
    end
    chk("send_accepted", 128'(k < 200), 128'(1));
    cyc(1);
    cmd_if.cmd_vld_i = 1'b0;
  endtask

  task automatic do_key(input logic [127:0] key);
    int n;
    send(CmdKey, 1'b0, key);
    chk("key_strobe", {gcm_key_vld_o, gcm_iv_vld_o}, 2'b10);
    chk("key_value", gcm_key_o, key);
    chk("key_clears_err", err_o, 1'b0);
    wait_hi(0, n);
    chk("key_stall_len", n, KeyLat);
  endtask

  task automatic pulse_core(input int nvld);
    for (int j = 0; j < nvld; j++) begin
      core_vld_i = 1'b1;
      cyc(1);
      core_vld_i = 1'b0;
    end
    core_tag_vld_i = 1'b1;
    cyc(1);
    core_tag_vld_i = 1'b0;
  endtask

  // One message: IV, na AAD then nd DATA (last on final block), nout core blocks, then tag.
  task automatic run_msg(input int na, input int nd, input int nout, input int gapmax,
                         input bit chk_b2b);
    logic [127:0] iv, d;
    logic [1:0]   t;
    logic         l;
    int           n, first_c, last_c;
    bit           exp_ok;
    iv = rand128();
    first_c = 0;
    last_c  = 0;
    send(CmdIv, 1'b0, iv);
    chk("iv_strobe", {gcm_iv_vld_o, busy_o}, 2'b11);
    chk("iv_data", 128'(gcm_data_o[127:32]), 128'(iv[127:32]));
    wait_hi(0, n);
    chk("iv_gap_len", n, IvGap);
    for (int i = 0; i < na + nd; i++) begin
      t = (i < na) ? CmdAad : CmdData;
      l = (i == na + nd - 1);
      d = rand128();
      send(t, l, d);
      chk("blk_strobe", {gcm_aad_vld_o, gcm_data_vld_o}, (t == CmdAad) ? 2'b10 : 2'b01);
      chk("blk_data", gcm_data_o, d);
      if (i == 0) first_c = cyc_cnt;
      last_c = cyc_cnt;
      if (!l && gapmax > 0) cyc($urandom_range(0, gapmax));
    end
    chk("rdy_low_after_last", cmd_if.cmd_rdy_o, 1'b0);
    cyc(1);
    chk("end_after_last", {gcm_end_o, gcm_aad_vld_o, gcm_data_vld_o}, 3'b100);
    if (chk_b2b) chk("b2b_span", last_c - first_c, na + nd - 1);
    pulse_core(nout);
    exp_ok = (nout == na + nd);
    chk("tag_done", done_o, exp_ok);
    chk("tag_err", err_o, !exp_ok);
    chk("tag_busy", busy_o, 1'b0);
    cyc(1);
    chk("done_one_cycle", done_o, 1'b0);
    if (!exp_ok) do_key(rand128());
  endtask

  initial begin
    int n, a0, d0, na, nd, nout;
    logic [127:0] tag_ref;
    tag_ref = 128'h58E2FCCEFA7E3061367F1D57A4E7455A;
    cmd_if.cmd_vld_i  = 1'b0;
    cmd_if.cmd_type_i = 2'b00;
    cmd_if.cmd_last_i = 1'b0;
    cmd_if.cmd_data_i = '0;
    core_vld_i     = 1'b0;
    core_tag_vld_i = 1'b0;
    rst_n          = 1'b0;
    cyc(3);
    chk("rst_flags", {cmd_if.cmd_rdy_o, gcm_key_vld_o, gcm_iv_vld_o, gcm_aad_vld_o,
                      gcm_data_vld_o, gcm_end_o, busy_o, done_o, err_o}, 9'h0);
    chk("rst_key", gcm_key_o, 128'h0);
    chk("rst_blk", gcm_data_o, 128'h0);
    rst_n = 1'b1;
    cyc(1);
    chk("idle_rdy", cmd_if.cmd_rdy_o, 1'b1);

    // Zero key, empty message (IV last=1); the tag value itself is not seen by the sequencer.
    do_key('0);
    send(CmdIv, 1'b1, '0);
    chk("empty_iv_strobe", {gcm_iv_vld_o, busy_o}, 2'b11);
    wait_hi(1, n);
    chk("empty_end_delay", n, IvGap + 1);
    chk("empty_busy", busy_o, 1'b1);
    pulse_core(0);
    chk("empty_done", {done_o, busy_o, err_o}, 3'b100);
    cyc(1);
    chk("empty_done_pulse", done_o, 1'b0);
    chk("tag_ref_unused", 128'(tag_ref != 0), 128'(1));

    // 2 AAD + 3 DATA back-to-back.
    run_msg(2, 3, 5, 0, 1'b1);

    // AAD after DATA is an ordering error; the AAD is dropped.
    send(CmdIv, 1'b0, rand128());
    send(CmdData, 1'b0, rand128());
    a0 = n_aad;
    send(CmdAad, 1'b0, rand128());
    chk("aad_after_data", {err_o, busy_o, gcm_aad_vld_o}, 3'b100);
    cyc(1);
    chk("aad_dropped", n_aad - a0, 0);
    do_key(rand128());

    // DATA with no IV is dropped.
    d0 = n_data;
    send(CmdData, 1'b0, rand128());
    chk("data_no_iv", {err_o, gcm_data_vld_o}, 2'b10);
    cyc(1);
    chk("data_no_iv_dropped", n_data - d0, 0);
    do_key(rand128());

    // Spurious core output while idle in READY.
    core_vld_i = 1'b1;
    cyc(1);
    core_vld_i = 1'b0;
    chk("spurious_vld", err_o, 1'b1);
    do_key(rand128());

    // Tag withheld: error exactly TagTmo cycles after entering the tag wait.
    send(CmdIv, 1'b0, rand128());
    send(CmdAad, 1'b0, rand128());
    send(CmdData, 1'b1, rand128());
    cyc(TagTmo - 1);
    chk("tmo_not_yet", err_o, 1'b0);
    cyc(1);
    chk("tmo_err", {err_o, busy_o}, 2'b10);
    do_key(rand128());

    // Count mismatch: 4 in, 3 out.
    run_msg(2, 2, 3, 0, 1'b0);

    // Random messages with random pacing; occasionally one core block short.
    for (int r = 0; r < 4; r++) begin
      na   = $urandom_range(0, 3);
      nd   = $urandom_range(1, 3);
      nout = ($urandom_range(0, 3) == 0) ? na + nd - 1 : na + nd;
      run_msg(na, nd, nout, 2, 1'b0);
    end

    // Reset in the middle of DATA.
    send(CmdIv, 1'b0, rand128());
    send(CmdData, 1'b0, rand128());
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_flags", {cmd_if.cmd_rdy_o, gcm_key_vld_o, gcm_iv_vld_o, gcm_aad_vld_o,
                         gcm_data_vld_o, gcm_end_o, busy_o, done_o, err_o}, 9'h0);
    chk("midrst_key", gcm_key_o, 128'h0);
    chk("midrst_blk", gcm_data_o, 128'h0);
    rst_n = 1'b1;
    cyc(1);
    send(CmdIv, 1'b0, rand128());
    chk("iv_needs_key", {err_o, gcm_iv_vld_o, busy_o}, 3'b100);
    do_key(rand128());
    run_msg(1, 1, 2, 1, 1'b0);

    chk("one_strobe_per_cycle", n_multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
